// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin arbiter sharing one single-port SRAM among NUM_REQ requesters
// Optional SRAM_CLEAR_EN: sweeps RESET_VALUE into every word after reset before serving requests.
module sram_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int NUM_REQ = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_write,
  input  logic [NUM_REQ*AW-1:0]    req_addr,
  input  logic [NUM_REQ*WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]         resp_data,
  output logic                     busy,
  output logic                     sram_write_enable,
  output logic [AW-1:0]            sram_addr,
  output logic [WIDTH-1:0]         sram_write_word,
  input  logic [WIDTH-1:0]         sram_word
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]      ptr;
  logic [PW-1:0]      grant_idx;
  logic [PW-1:0]      next_ptr;
  logic [PW-1:0]      cmd_id;
  logic [NUM_REQ-1:0] grant;
  logic               found;
  logic               cmd_rd;
  logic               in_serve;
  logic               clr_active;
  logic [AW-1:0]      clr_addr;
  int                 idx;

`ifdef SRAM_CLEAR_EN
  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_SERVE = 1'b1;

  logic state;

  // Gating with reset keeps every output low while reset is held.
  assign clr_active = reset && (state == ST_CLEAR);
  assign in_serve   = reset && (state == ST_SERVE);
  assign busy       = clr_active;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else if (state == ST_CLEAR) begin
      clr_addr <= clr_addr + 1'b1;
      if (clr_addr == AW'(DEPTH - 1)) begin
        state <= ST_SERVE;
      end
    end
  end
`else
  assign clr_active = 1'b0;
  assign in_serve   = reset;
  assign busy       = 1'b0;
  assign clr_addr   = '0;
`endif

  // First valid requester at or after the pointer, wrapping, wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (in_serve && !found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = PW'(idx);
        found      = 1'b1;
      end
    end
  end

  assign req_ready = grant;
  assign next_ptr  = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr               <= '0;
      sram_write_enable <= 1'b0;
      sram_addr         <= '0;
      sram_write_word   <= '0;
      cmd_rd            <= 1'b0;
      cmd_id            <= '0;
      resp_valid        <= '0;
      resp_data         <= '0;
    end else begin
      sram_write_enable <= 1'b0;
      cmd_rd            <= 1'b0;
      if (clr_active) begin
        sram_write_enable <= 1'b1;
        sram_addr         <= clr_addr;
        sram_write_word   <= RESET_VALUE;
      end else if (found) begin
        sram_write_enable <= req_write[grant_idx];
        sram_addr         <= req_addr[grant_idx*AW +: AW];
        sram_write_word   <= req_wdata[grant_idx*WIDTH +: WIDTH];
        cmd_rd            <= ~req_write[grant_idx];
        cmd_id            <= grant_idx;
        ptr               <= next_ptr;
      end
      // sram_word reflects the read address presented this cycle.
      resp_valid <= '0;
      if (cmd_rd) begin
        resp_valid[cmd_id] <= 1'b1;
        resp_data          <= sram_word;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed table-driven bench for sram_arbiter with a behavioural SRAM
// Define SRAM_CLEAR_EN to run the clear-sweep sequence (DEPTH=8, RESET_VALUE=7) instead.
module tb_sram_arbiter;

`ifdef SRAM_CLEAR_EN
  localparam int DEPTH = 8;
  localparam logic [31:0] RV = 32'd7;
`else
  localparam int DEPTH = 256;
  localparam logic [31:0] RV = 32'd0;
`endif
  localparam int AW = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [1:0]    req_write;
  logic [2*AW-1:0] req_addr;
  logic [63:0]   req_wdata;
  logic [1:0]    resp_valid;
  logic [31:0]   resp_data;
  logic          busy;
  logic          sram_write_enable;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_write_word;
  logic [31:0]   sram_word;

  logic [31:0] mem [DEPTH];
  logic        preload;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_arbiter #(
    .WIDTH(32), .DEPTH(DEPTH), .NUM_REQ(2), .RESET_VALUE(RV)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy),
    .sram_write_enable(sram_write_enable), .sram_addr(sram_addr),
    .sram_write_word(sram_write_word), .sram_word(sram_word)
  );

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
      mem[3] <= 32'h11;
      mem[7] <= 32'h22;
    end else if (sram_write_enable) begin
      mem[sram_addr] <= sram_write_word;
    end
  end
  assign sram_word = mem[sram_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] w,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    req_valid = v;
    req_write = w;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ready"}, 32'(req_ready), 32'd0);
    chk({tag, " we"}, 32'(sram_write_enable), 32'd0);
    chk({tag, " addr"}, 32'(sram_addr), 32'd0);
    chk({tag, " wword"}, sram_write_word, 32'd0);
    chk({tag, " rv"}, 32'(resp_valid), 32'd0);
    chk({tag, " rdata"}, resp_data, 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
  endtask

`ifndef SRAM_CLEAR_EN
  typedef struct {
    logic [1:0]  v;
    logic [1:0]  w;
    logic [7:0]  a0;
    logic [7:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  e_rdy;
    logic        e_we;
    logic [7:0]  e_addr;
    logic [31:0] e_ww;
    logic [1:0]  e_rv;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl [22];
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b0;
    preload = 1'b1;
    drive(2'b00, 2'b00, '0, '0, 32'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_all_zero("reset");
    preload = 1'b0;

`ifndef SRAM_CLEAR_EN
    // Write/read, RAW, idle hold and interleaved reads as one continuous cycle table.
    tbl[0]  = '{2'b01, 2'b01, 8'd5,   8'd0,   32'd42, 32'd0,        2'b01, 1'b0, 8'd0,   32'd0,        2'b00, 32'd0};
    tbl[1]  = '{2'b01, 2'b00, 8'd5,   8'd0,   32'd0,  32'd0,        2'b01, 1'b1, 8'd5,   32'd42,       2'b00, 32'd0};
    tbl[2]  = '{2'b00, 2'b00, 8'd0,   8'd0,   32'd0,  32'd0,        2'b00, 1'b0, 8'd5,   32'd0,        2'b00, 32'd0};
    tbl[3]  = '{2'b00, 2'b00, 8'd0,   8'd0,   32'd0,  32'd0,        2'b00, 1'b0, 8'd5,   32'd0,        2'b01, 32'd42};
    tbl[4]  = '{2'b00, 2'b00, 8'd0,   8'd0,   32'd0,  32'd0,        2'b00, 1'b0, 8'd5,   32'd0,        2'b00, 32'd42};
    tbl[5]  = '{2'b10, 2'b10, 8'd0,   8'd200, 32'd0,  32'hDEADBEEF, 2'b10, 1'b0, 8'd5,   32'd0,        2'b00, 32'd42};
    tbl[6]  = '{2'b10, 2'b00, 8'd0,   8'd200, 32'd0,  32'd0,        2'b10, 1'b1, 8'd200, 32'hDEADBEEF, 2'b00, 32'd42};
    tbl[7]  = '{2'b00, 2'b00, 8'd0,   8'd0,   32'd0,  32'd0,        2'b00, 1'b0, 8'd200, 32'd0,        2'b00, 32'd42};
    tbl[8]  = '{2'b00, 2'b00, 8'd0,   8'd0,   32'd0,  32'd0,        2'b00, 1'b0, 8'd200, 32'd0,        2'b10, 32'hDEADBEEF};
    for (int i = 9; i < 14; i++)
      tbl[i] = '{2'b00, 2'b00, 8'd0, 8'd0, 32'd0, 32'd0, 2'b00, 1'b0, 8'd200, 32'd0, 2'b00, 32'hDEADBEEF};
    tbl[14] = '{2'b10, 2'b00, 8'd0,   8'd3,   32'd0,  32'd0,        2'b10, 1'b0, 8'd200, 32'd0,        2'b00, 32'hDEADBEEF};
    tbl[15] = '{2'b11, 2'b00, 8'd3,   8'd7,   32'd0,  32'd0,        2'b01, 1'b0, 8'd3,   32'd0,        2'b00, 32'hDEADBEEF};
    tbl[16] = '{2'b11, 2'b00, 8'd3,   8'd7,   32'd0,  32'd0,        2'b10, 1'b0, 8'd3,   32'd0,        2'b10, 32'h11};
    tbl[17] = '{2'b11, 2'b00, 8'd3,   8'd7,   32'd0,  32'd0,        2'b01, 1'b0, 8'd7,   32'd0,        2'b01, 32'h11};
    tbl[18] = '{2'b11, 2'b00, 8'd3,   8'd7,   32'd0,  32'd0,        2'b10, 1'b0, 8'd3,   32'd0,        2'b10, 32'h22};
    tbl[19] = '{2'b00, 2'b00, 8'd0,   8'd0,   32'd0,  32'd0,        2'b00, 1'b0, 8'd7,   32'd0,        2'b01, 32'h11};
    tbl[20] = '{2'b00, 2'b00, 8'd0,   8'd0,   32'd0,  32'd0,        2'b00, 1'b0, 8'd7,   32'd0,        2'b10, 32'h22};
    tbl[21] = '{2'b00, 2'b00, 8'd0,   8'd0,   32'd0,  32'd0,        2'b00, 1'b0, 8'd7,   32'd0,        2'b00, 32'h22};

    reset = 1'b1;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].w, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
      #1;
      chk($sformatf("tbl%0d ready", i), 32'(req_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d we", i), 32'(sram_write_enable), 32'(tbl[i].e_we));
      chk($sformatf("tbl%0d addr", i), 32'(sram_addr), 32'(tbl[i].e_addr));
      if (tbl[i].e_we) chk($sformatf("tbl%0d wword", i), sram_write_word, tbl[i].e_ww);
      chk($sformatf("tbl%0d rv", i), 32'(resp_valid), 32'(tbl[i].e_rv));
      chk($sformatf("tbl%0d rdata", i), resp_data, tbl[i].e_rd);
      chk($sformatf("tbl%0d busy", i), 32'(busy), 32'd0);
    end

    // Contention straight out of reset: grants alternate, responses follow two cycles later.
    @(negedge clk);
    reset = 1'b0;
    drive(2'b11, 2'b00, 8'd3, 8'd7, 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("cont%0d ready", k), 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k >= 2) begin
        chk($sformatf("cont%0d rv", k), 32'(resp_valid), (k % 2 == 0) ? 32'd1 : 32'd2);
        chk($sformatf("cont%0d rdata", k), resp_data, (k % 2 == 0) ? 32'h11 : 32'h22);
      end else begin
        chk($sformatf("cont%0d rv", k), 32'(resp_valid), 32'd0);
      end
    end

    // Reset arriving one cycle after a read handshake drops the response and the pointer.
    @(negedge clk);
    drive(2'b01, 2'b00, 8'd3, 8'd0, 32'd0, 32'd0);
    #1;
    chk("rstmid hs ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    drive(2'b00, 2'b00, 8'd0, 8'd0, 32'd0, 32'd0);
    #1;
    chk_all_zero("rstmid");
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rstmid post%0d rv", k), 32'(resp_valid), 32'd0);
    end
    @(negedge clk);
    drive(2'b11, 2'b00, 8'd3, 8'd7, 32'd0, 32'd0);
    #1;
    chk("rstmid first grant", 32'(req_ready), 32'd1);
    @(negedge clk);
    drive(2'b00, 2'b00, 8'd0, 8'd0, 32'd0, 32'd0);
`else
    // Clear sweep: busy and blocked for DEPTH cycles, writes of RV to 0..DEPTH-1, then a read.
    drive(2'b01, 2'b00, 3'd4, 3'd0, 32'd0, 32'd0);
    reset = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 9) drive(2'b00, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0);
      #1;
      if (k <= 9) begin
        chk($sformatf("clr%0d busy", k), 32'(busy), (k <= 7) ? 32'd1 : 32'd0);
        chk($sformatf("clr%0d ready", k), 32'(req_ready), (k <= 7 || k == 9) ? 32'd0 : 32'd1);
      end
      if (k >= 1 && k <= 8) begin
        chk($sformatf("clr%0d we", k), 32'(sram_write_enable), 32'd1);
        chk($sformatf("clr%0d addr", k), 32'(sram_addr), 32'(k - 1));
        chk($sformatf("clr%0d wword", k), sram_write_word, 32'd7);
      end
      if (k == 9) begin
        chk("clr9 we", 32'(sram_write_enable), 32'd0);
        chk("clr9 addr", 32'(sram_addr), 32'd4);
      end
      if (k == 10) begin
        chk("clr10 rv", 32'(resp_valid), 32'd1);
        chk("clr10 rdata", resp_data, 32'd7);
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Round-robin arbiter that shares one single-port sram instance (WIDTH x DEPTH, synchronous write, combinational read of the presented address) between NUM_REQ neuron-side requesters.
- Each requester uses a valid/ready request channel and a response strobe.
- The block registers the SRAM command, returns read data two cycles after handshake and sustains one access per cycle.
- Sits between the neuron update/readout logic and the state SRAM.

Parameters:
- WIDTH, 32, data word width; matches the sram WIDTH.
- DEPTH, 256, number of SRAM words; AW = $clog2(DEPTH).
- NUM_REQ, 2, number of requesters (>=2).
- RESET_VALUE, 0, value written to every word by the clear sweep (SRAM_CLEAR_EN only).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant (one-hot or zero).
- req_write  in  NUM_REQ  per-requester 1 = write, 0 = read.
- req_addr  in  NUM_REQ*AW  flattened addresses; requester i in [i*AW +: AW].
- req_wdata  in  NUM_REQ*WIDTH  flattened write data; requester i in [i*WIDTH +: WIDTH].
- resp_valid  out  NUM_REQ  one-cycle read-data strobe to the originating requester.
- resp_data  out  WIDTH  read data, valid while any resp_valid bit is high.
- busy  out  1  high while the clear sweep runs; always 0 without SRAM_CLEAR_EN.
- sram_write_enable  out  1  to sram write_enable.
- sram_addr  out  AW  to sram addr.
- sram_write_word  out  WIDTH  to sram write_word.
- sram_word  in  WIDTH  from sram word.

Behaviour:
- Reset (reset == 0, asynchronous): all outputs 0; round-robin pointer = 0 (requester 0 highest priority); pending-read pipeline cleared; in-flight reads dropped with no resp_valid.
- State machine:
  - States: CLEAR (only with SRAM_CLEAR_EN) and SERVE.
  - Reset enters CLEAR if the macro is defined, otherwise SERVE.
- Grant, combinational in SERVE:
  - Search req_valid starting at the pointer and wrapping modulo NUM_REQ; the first set bit wins.
  - req_ready has that bit only; all zero if no valid or not in SERVE.
  - A handshake is req_valid[i] & req_ready[i].
- Pointer: after a handshake by requester i, the pointer becomes (i+1) mod NUM_REQ. It is unchanged when there is no handshake.
  - Any requester holding valid is granted within NUM_REQ cycles.
- Pipeline, handshake in cycle t:
  - Cycle t+1: sram_addr = req_addr[i], sram_write_word = req_wdata[i], sram_write_enable = req_write[i]. A write commits at the end of t+1.
  - Read: sram_word is sampled at the end of t+1. In cycle t+2, resp_valid[i] = 1 and resp_data = sampled word.
  - With no handshake in cycle t, cycle t+1 has sram_write_enable = 0. sram_addr and sram_write_word hold their previous values.
- Throughput: one handshake per cycle, back-to-back, mixed requesters.
- Read-after-write: a write handshaked at t and a read of the same address at t+1 returns the new data. Guaranteed by ordering; no bypass logic.
- Writes produce no response. resp_data holds its last value when no resp_valid bit is set.
- Requester inputs need only be stable during the handshake cycle.
- Out-of-range addresses are impossible when DEPTH is a power of two. For other DEPTH, the address is passed through unchecked.

Optional Feature:
- Macro: SRAM_CLEAR_EN.
- Defined:
  - After reset deasserts, the FSM is in CLEAR with busy = 1 and req_ready = 0.
  - An internal counter writes RESET_VALUE to addresses 0..DEPTH-1, one per cycle, through the sram_* outputs with sram_write_enable = 1.
  - After address DEPTH-1 it enters SERVE; busy falls in the cycle after the last clear write.
  - Reset during CLEAR restarts the sweep at address 0.
- Not defined: no CLEAR state or counter; busy tied 0; SERVE is available in the first cycle after reset.

Test Plan:
- Single write then read: requester 0 writes 42 to addr 5; next cycle reads addr 5 -> resp_valid[0] two cycles after the read handshake with resp_data = 42; resp_valid[1] stays 0.
- Contention: both requesters hold valid reads of addrs 3 and 7 (preloaded 0x11, 0x22) continuously from reset -> grants alternate 0,1,0,1; responses 0x11/0x22 alternate on resp_valid[0]/[1], one per cycle.
- Back-to-back RAW: requester 1 writes 0xDEADBEEF to addr 200 at t and reads addr 200 at t+1 -> resp_data = 0xDEADBEEF at t+3.
- Idle hold: no valid for 5 cycles -> sram_write_enable = 0, resp_valid = 0 throughout, pointer unchanged; the next lone request from requester 1 is granted the same cycle.
- Reset mid-read: read handshake at t, reset asserted at t+1 -> all outputs 0 immediately, no resp_valid after release, first grant after release goes to requester 0.
- SRAM_CLEAR_EN, DEPTH=8, RESET_VALUE=7: busy = 1 for 8 cycles with writes to addrs 0..7; requests blocked meanwhile; a subsequent read of addr 4 returns 7.
